// File: rtl/team_10_wb_regs.sv
// team_10_wb_regs: Wishbone classic register block for 34 GPIO lines with rising-edge interrupts
module team_10_wb_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [33:0] gpio_in,
  output logic [33:0] gpio_out,
  output logic [33:0] gpio_oeb,
  output logic        irq_o
);
  typedef enum logic {IDLE, ACK} state_t;
  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [33:0] out_q, out_d, oeb_q, oeb_d;
  logic [33:0] s1_q, s1_d, s2_q, s2_d, p_q, p_d;
  logic [31:0] en_q, en_d, stat_q, stat_d;
  logic [31:0] m, rd, clr;
  logic [2:0]  idx;
  logic        hit, acc, wr;
  logic        unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];
  always_comb begin
    hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    acc = (state_q == IDLE) & hit;
    wr  = acc & wbs_we_i;
    idx = wbs_adr_i[4:2];
    m   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    case (idx)
      3'd0:    rd = out_q[31:0];
      3'd1:    rd = {30'd0, out_q[33:32]};
      3'd2:    rd = oeb_q[31:0];
      3'd3:    rd = {30'd0, oeb_q[33:32]};
      3'd4:    rd = s2_q[31:0];
      3'd5:    rd = {30'd0, s2_q[33:32]};
      3'd6:    rd = en_q;
      default: rd = stat_q;
    endcase
    out_d = out_q;
    oeb_d = oeb_q;
    en_d  = en_q;
    if (wr)
      case (idx)
        3'd0:    out_d[31:0]  = (out_q[31:0] & ~m) | (wbs_dat_i & m);
        3'd1:    out_d[33:32] = m[0] ? wbs_dat_i[1:0] : out_q[33:32];
        3'd2:    oeb_d[31:0]  = (oeb_q[31:0] & ~m) | (wbs_dat_i & m);
        3'd3:    oeb_d[33:32] = m[0] ? wbs_dat_i[1:0] : oeb_q[33:32];
        3'd6:    en_d         = (en_q & ~m) | (wbs_dat_i & m);
        default: ;
      endcase
    // a new edge is ORed in after the clear so set beats W1C on the same bit
    clr     = (wr && idx == 3'd7) ? (wbs_dat_i & m) : 32'd0;
    stat_d  = (stat_q & ~clr) | (s2_q[31:0] & ~p_q[31:0] & en_q);
    s1_d    = gpio_in;
    s2_d    = s1_q;
    p_d     = s2_q;
    state_d = acc ? ACK : IDLE;
    ack_d   = acc;
    dat_d   = (acc && !wbs_we_i) ? rd : 32'd0;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      out_q   <= 34'd0;
      oeb_q   <= {34{1'b1}};
      en_q    <= 32'd0;
      stat_q  <= 32'd0;
      s1_q    <= 34'd0;
      s2_q    <= 34'd0;
      p_q     <= 34'd0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      out_q   <= out_d;
      oeb_q   <= oeb_d;
      en_q    <= en_d;
      stat_q  <= stat_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      p_q     <= p_d;
    end
  end
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign gpio_out  = out_q;
  assign gpio_oeb  = oeb_q;
  assign irq_o     = |stat_q;
endmodule

// File: tb/tb_team_10_wb_regs.sv
// tb_team_10_wb_regs: directed bench with a per-cycle register-map model of team_10_wb_regs
module tb_team_10_wb_regs;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic        clk = 0, rst = 1;
  logic        cyc = 0, stb = 0, we = 0;
  logic [3:0]  sel = 0;
  logic [31:0] adr = 0, wdat = 0;
  logic        ack, irq;
  logic [31:0] rdat;
  logic [33:0] gin = 0, gout, goeb;
  int errors = 0, checks = 0;
  bit mon_en = 0;

  team_10_wb_regs #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .gpio_in(gin), .gpio_out(gout), .gpio_oeb(goeb), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: register map as plain values, pads seen through a 3-deep sample history
  logic [33:0] m_out = 0, m_oeb = '1;
  logic [31:0] m_en = 0, m_stat = 0, m_dat = 0;
  logic [33:0] hist [3] = '{default: 0};
  bit m_ack = 0, m_rd = 0, m_busy = 0;

  function automatic logic [31:0] m_read(input logic [2:0] r);
    logic [31:0] v;
    case (r)
      0: v = m_out[31:0];
      1: v = {30'd0, m_out[33:32]};
      2: v = m_oeb[31:0];
      3: v = {30'd0, m_oeb[33:32]};
      4: v = hist[1][31:0];
      5: v = {30'd0, hist[1][33:32]};
      6: v = m_en;
      default: v = m_stat;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v = old;
    for (int k = 0; k < 4; k++) if (s[k]) v[8*k +: 8] = d[8*k +: 8];
    return v;
  endfunction

  always @(posedge clk) begin
    logic [31:0] rise, clr, lo, hi;
    logic [2:0] r;
    bit take;
    if (rst) begin
      m_out = 0; m_oeb = '1; m_en = 0; m_stat = 0; m_dat = 0;
      m_ack = 0; m_rd = 0; m_busy = 0;
      hist = '{default: 0};
    end else begin
      rise = hist[1][31:0] & ~hist[2][31:0] & m_en;
      take = !m_busy && cyc && stb && adr[31:5] == BASE[31:5];
      r = adr[4:2];
      clr = 0;
      m_rd = take && !we;
      m_dat = m_rd ? m_read(r) : 0;
      if (take && we) begin
        lo = lanes(m_read(r), wdat, sel);
        hi = lanes(m_read(r), wdat, sel) & 32'h3;
        case (r)
          0: m_out[31:0] = lo;
          1: m_out[33:32] = hi[1:0];
          2: m_oeb[31:0] = lo;
          3: m_oeb[33:32] = hi[1:0];
          6: m_en = lo;
          7: clr = lanes(0, wdat, sel);
          default: ;
        endcase
      end
      m_stat = (m_stat & ~clr) | rise;
      m_ack = take;
      m_busy = take;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = gin;
    end
  end

  always @(negedge clk) if (mon_en) begin
    check("mon_ack", ack, m_ack);
    if (!m_ack || m_rd) check("mon_dat", rdat, m_dat);
    check("mon_out", gout, m_out);
    check("mon_oeb", goeb, m_oeb);
    check("mon_irq", irq, m_stat != 0);
  end

  task automatic wb(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                    output logic [31:0] q);
    int n = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; sel = s; adr = a; wdat = d;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    check("ack_latency", n, 1);
    q = rdat;
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    check("ack_one_cycle", ack, 0);
  endtask

  initial begin
    logic [31:0] q;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_oeb", goeb, 34'h3_FFFF_FFFF);
    check("rst_out", gout, 0);
    check("rst_ack", ack, 0);
    check("rst_irq", irq, 0);
    @(negedge clk); rst = 0; mon_en = 1;

    wb(BASE + 32'h00, 1, 4'b0101, 32'hDEAD_BEEF, q);
    check("out_lanes", gout[31:0], 32'h00AD_00EF);
    wb(BASE + 32'h00, 0, 4'b0000, 0, q);
    check("out_readback", q, 32'h00AD_00EF);
    wb(BASE + 32'h03, 1, 4'b0000, 32'hFFFF_FFFF, q);
    check("sel0_nochange", gout[31:0], 32'h00AD_00EF);

    wb(BASE + 32'h0C, 1, 4'b0001, 32'h0, q);
    check("oeb_hi_clear", goeb[33:32], 2'b00);
    wb(BASE + 32'h0C, 1, 4'b1111, 32'hFFFF_FFFF, q);
    check("oeb_hi_set", goeb[33:32], 2'b11);
    wb(BASE + 32'h0C, 0, 4'b0000, 0, q);
    check("oeb_hi_read", q, 32'h3);

    @(negedge clk); gin[33] = 1;
    repeat (3) @(posedge clk);
    wb(BASE + 32'h14, 0, 4'b1111, 0, q);
    check("in_hi_read", q, 32'h2);
    wb(BASE + 32'h14, 1, 4'b1111, 32'h0, q);
    wb(BASE + 32'h14, 0, 4'b1111, 0, q);
    check("in_hi_ro", q, 32'h2);

    @(negedge clk); cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = BASE + 32'h20; wdat = 32'h5555_5555;
    n = 0;
    repeat (5) begin @(posedge clk); #1; if (ack) n++; end
    cyc = 0; stb = 0; we = 0;
    check("miss_no_ack", n, 0);
    check("miss_out", gout[31:0], 32'h00AD_00EF);

    @(negedge clk); cyc = 1; stb = 1; adr = BASE + 32'h00;
    n = 0;
    repeat (6) begin @(posedge clk); #1; if (ack) n++; end
    cyc = 0; stb = 0;
    check("throughput", n, 3);
    @(posedge clk);

    wb(BASE + 32'h18, 1, 4'b1111, 32'h1, q);
    @(negedge clk); gin[0] = 1;
    repeat (2) @(posedge clk);
    #1; check("irq_not_yet", irq, 0);
    @(posedge clk); #1; check("irq_after3", irq, 1);
    wb(BASE + 32'h10, 0, 4'b1111, 0, q);
    check("in_lo_read", q, 32'h1);
    wb(BASE + 32'h1C, 0, 4'b1111, 0, q);
    check("stat_read", q, 32'h1);
    wb(BASE + 32'h1C, 1, 4'b0001, 32'h1, q);
    check("irq_cleared", irq, 0);
    @(negedge clk); gin[0] = 0;
    repeat (4) @(posedge clk);
    @(negedge clk); gin[0] = 1;
    repeat (4) @(posedge clk);
    #1; check("irq_reassert", irq, 1);

    @(negedge clk); gin[0] = 0;
    repeat (5) @(posedge clk);
    @(negedge clk); gin[0] = 1;
    @(posedge clk);
    @(posedge clk);
    wb(BASE + 32'h1C, 1, 4'b1111, 32'h1, q);
    check("collision_set_wins", irq, 1);

    @(negedge clk); cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = BASE; wdat = 32'h1234_5678;
    @(posedge clk); #1;
    check("mid_ack", ack, 1);
    check("mid_write", gout[31:0], 32'h1234_5678);
    rst = 1; cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_out", gout, 0);
    check("mid_rst_oeb", goeb, 34'h3_FFFF_FFFF);
    check("mid_rst_irq", irq, 0);
    @(negedge clk); rst = 0; gin = 0;
    repeat (4) @(posedge clk);
    #1; check("no_irq_after_rst", irq, 0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
